// File: rtl/adf_pkg.sv
// Shared ADF PLL SPI frame definitions, matching the transmit side's frame layout.
package adf_pkg;

   localparam int unsigned ADF_FRAME_BITS = 32;
   localparam int unsigned ADF_NUM_REGS   = 6;
   localparam int unsigned ADF_ADDR_LSB   = 0;
   localparam int unsigned ADF_ADDR_W     = 3;
   localparam int unsigned ADF_BUS_W      = 16;
   localparam int unsigned ADF_FCNT_W     = 8;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StEval
   } mon_state_e;

   function automatic logic [ADF_ADDR_W-1:0] adf_addr(input logic [ADF_FRAME_BITS-1:0] word);
      return word[ADF_ADDR_LSB +: ADF_ADDR_W];
   endfunction

endpackage

// File: rtl/adf_spi_monitor_if.sv
// SPI snoop inputs plus PXI readback and frame status for the ADF SPI monitor.
interface adf_spi_monitor_if;
   import adf_pkg::*;

   logic                      spi_cs;
   logic                      spi_din;
   logic                      spi_sclk;
   logic [ADF_ADDR_W-1:0]     rd_sel;
   logic                      rd_hi;
   logic                      err_clr;
   logic [ADF_BUS_W-1:0]      rdata;
   logic [ADF_FRAME_BITS-1:0] frame_word;
   logic                      frame_valid;
   logic                      frame_err;
   logic [ADF_FCNT_W-1:0]     frame_cnt;

   modport master (
      output spi_cs, spi_din, spi_sclk, rd_sel, rd_hi, err_clr,
      input  rdata, frame_word, frame_valid, frame_err, frame_cnt
   );

   modport slave (
      input  spi_cs, spi_din, spi_sclk, rd_sel, rd_hi, err_clr,
      output rdata, frame_word, frame_valid, frame_err, frame_cnt
   );

endinterface

// File: rtl/sync_edge.sv
// Multi-stage synchronizer with programmable reset value and rise/fall pulses
// taken from the last stage against a one-cycle delayed copy.
module sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic clrn_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   always_ff @(posedge clk_i) begin
      if (!clrn_i) begin
         sync_q <= {STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~dly_q;
   assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/adf_spi_monitor.sv
// Passive ADF PLL SPI snooper: rebuilds 32-bit frames, decodes the control bits
// into a shadow register bank and serves it back as 16-bit halves.
module adf_spi_monitor
   import adf_pkg::*;
#(
   parameter int unsigned FRAME_BITS  = ADF_FRAME_BITS,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned NUM_REGS    = ADF_NUM_REGS,
   parameter int unsigned CNT_W       = 6
) (
   input logic              clk_100M,
   input logic              clrn,
   adf_spi_monitor_if.slave bus_io
);

   localparam int unsigned AddrExtW = ADF_ADDR_W + 1;
   typedef logic [AddrExtW-1:0] addr_ext_t;
   localparam logic [CNT_W-1:0] FrameCnt = CNT_W'(FRAME_BITS);
   localparam addr_ext_t        NumRegs  = addr_ext_t'(NUM_REGS);

   logic cs_q, cs_rise, cs_fall;
   logic sclk_q, sclk_rise, sclk_fall;
   logic din_q, din_rise, din_fall;

   sync_edge #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(1'b1)
   ) u_sync_cs (
      .clk_i (clk_100M),
      .clrn_i(clrn),
      .d_i   (bus_io.spi_cs),
      .q_o   (cs_q),
      .rise_o(cs_rise),
      .fall_o(cs_fall)
   );

   sync_edge #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(1'b0)
   ) u_sync_sclk (
      .clk_i (clk_100M),
      .clrn_i(clrn),
      .d_i   (bus_io.spi_sclk),
      .q_o   (sclk_q),
      .rise_o(sclk_rise),
      .fall_o(sclk_fall)
   );

   sync_edge #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(1'b0)
   ) u_sync_din (
      .clk_i (clk_100M),
      .clrn_i(clrn),
      .d_i   (bus_io.spi_din),
      .q_o   (din_q),
      .rise_o(din_rise),
      .fall_o(din_fall)
   );

   logic unused_edges;
   assign unused_edges = ^{sclk_q, sclk_fall, din_rise, din_fall};

   mon_state_e                state_q, state_d;
   logic                      armed_q, armed_d;
   logic                      pend_q, pend_d;
   logic [SYNC_STAGES:0]      fill_q, fill_d;
   logic [ADF_FRAME_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [ADF_FRAME_BITS-1:0] word_q, word_d;
   logic                      valid_q, valid_d;
   logic                      err_q, err_d;
   logic [ADF_FCNT_W-1:0]     fcnt_q, fcnt_d;
   logic [ADF_BUS_W-1:0]      rdata_q, rdata_d;
   logic [ADF_FRAME_BITS-1:0] bank_q [NUM_REGS];

   logic                  err_set;
   logic                  bank_we;
   logic [ADF_ADDR_W-1:0] addr;
   logic                  addr_ok;

   assign addr    = adf_addr(shift_q);
   assign addr_ok = {1'b0, addr} < NumRegs;

   // Synchronizer reset values must drain before cs can be trusted, otherwise a
   // reset released mid-frame would arm on the reset value and see a false fall.
   assign fill_d  = {fill_q[SYNC_STAGES-1:0], 1'b1};
   assign armed_d = armed_q | (fill_q[SYNC_STAGES] & cs_q);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = 1'b0;
      fcnt_d  = fcnt_q;
      pend_d  = 1'b0;
      err_set = 1'b0;
      bank_we = 1'b0;
      unique case (state_q)
         StIdle: begin
            if ((cs_fall || pend_q) && armed_q) begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            // cs rise wins over a coincident sclk rise
            if (cs_rise) begin
               state_d = StEval;
            end else if (sclk_rise) begin
               shift_d = {shift_q[ADF_FRAME_BITS-2:0], din_q};
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
         end
         StEval: begin
            pend_d  = cs_fall;
            state_d = StIdle;
            if (cnt_q == FrameCnt) begin
               word_d  = shift_q;
               valid_d = 1'b1;
               fcnt_d  = fcnt_q + 1'b1;
               if (addr_ok) bank_we = 1'b1;
               else         err_set = 1'b1;
            end else begin
               err_set = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      if (err_set)             err_d = 1'b1;
      else if (bus_io.err_clr) err_d = 1'b0;
      else                     err_d = err_q;
   end

   always_comb begin
      rdata_d = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if ({1'b0, bus_io.rd_sel} == addr_ext_t'(i)) begin
            rdata_d = bus_io.rd_hi ? bank_q[i][ADF_FRAME_BITS-1:ADF_BUS_W]
                                   : bank_q[i][ADF_BUS_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_100M) begin
      if (!clrn) begin
         state_q <= StIdle;
         armed_q <= 1'b0;
         pend_q  <= 1'b0;
         fill_q  <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         fcnt_q  <= '0;
         rdata_q <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         pend_q  <= pend_d;
         fill_q  <= fill_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         fcnt_q  <= fcnt_d;
         rdata_q <= rdata_d;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bank_we && ({1'b0, addr} == addr_ext_t'(i))) bank_q[i] <= shift_q;
         end
      end
   end

   assign bus_io.rdata       = rdata_q;
   assign bus_io.frame_word  = word_q;
   assign bus_io.frame_valid = valid_q;
   assign bus_io.frame_err   = err_q;
   assign bus_io.frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_adf_spi_monitor.sv
// Directed bench for adf_spi_monitor: bit-banged SPI frames, readback and status checks.
module tb_adf_spi_monitor;

   logic clk;
   logic clrn;
   int   checks;
   int   errors;
   int   valid_seen;

   adf_spi_monitor_if bus ();

   adf_spi_monitor u_dut (
      .clk_100M(clk),
      .clrn    (clrn),
      .bus_io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial valid_seen = 0;
   always @(negedge clk) if (bus.frame_valid === 1'b1) valid_seen <= valid_seen + 1;

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic send_bits(input logic [63:0] data, input int nbits, input int half);
      bus.spi_cs = 1'b0;
      repeat (half) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.spi_din = data[i];
         repeat (half) @(negedge clk);
         bus.spi_sclk = 1'b1;
         repeat (half) @(negedge clk);
         bus.spi_sclk = 1'b0;
      end
      repeat (half) @(negedge clk);
      bus.spi_cs = 1'b1;
   endtask

   task automatic read_reg(input logic [2:0] sel, input logic hi, output logic [15:0] v);
      bus.rd_sel = sel;
      bus.rd_hi  = hi;
      @(negedge clk);
      v = bus.rdata;
   endtask

   task automatic pulse_err_clr();
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      repeat (3) @(negedge clk);
      checks += 5;
      if (bus.frame_word !== 32'h0) begin errors++; $display("FAIL rst_word got %h want 0", bus.frame_word); end
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.frame_valid); end
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.frame_err); end
      if (bus.frame_cnt !== 8'h0) begin errors++; $display("FAIL rst_cnt got %0d want 0", bus.frame_cnt); end
      if (bus.rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
      clrn = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_r5();
      int          v0;
      logic [15:0] rd;
      v0 = valid_seen;
      send_bits(64'h00580005, 32, 50);
      repeat (8) @(negedge clk);
      checks += 4;
      if (valid_seen - v0 != 1) begin errors++; $display("FAIL r5_pulses got %0d want 1", valid_seen - v0); end
      if (bus.frame_word !== 32'h00580005) begin errors++; $display("FAIL r5_word got %h want 00580005", bus.frame_word); end
      if (bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL r5_cnt got %0d want 1", bus.frame_cnt); end
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL r5_err got %b want 0", bus.frame_err); end
      read_reg(3'd5, 1'b0, rd);
      checks++;
      if (rd !== 16'h0005) begin errors++; $display("FAIL r5_lo got %h want 0005", rd); end
      read_reg(3'd5, 1'b1, rd);
      checks++;
      if (rd !== 16'h0058) begin errors++; $display("FAIL r5_hi got %h want 0058", rd); end
   endtask

   task automatic test_bad_len();
      int          lens[2] = '{31, 33};
      int          v0;
      logic [15:0] rd;
      for (int k = 0; k < 2; k++) begin
         v0 = valid_seen;
         send_bits(64'h1_0000_0002, lens[k], 3);
         repeat (8) @(negedge clk);
         checks += 4;
         if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL len%0d_err got %b want 1", lens[k], bus.frame_err); end
         if (valid_seen != v0) begin errors++; $display("FAIL len%0d_pulses got %0d want 0", lens[k], valid_seen - v0); end
         if (bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL len%0d_cnt got %0d want 1", lens[k], bus.frame_cnt); end
         if (bus.frame_word !== 32'h00580005) begin errors++; $display("FAIL len%0d_word got %h want 00580005", lens[k], bus.frame_word); end
         read_reg(3'd5, 1'b0, rd);
         checks++;
         if (rd !== 16'h0005) begin errors++; $display("FAIL len%0d_bank5 got %h want 0005", lens[k], rd); end
         read_reg(3'd2, 1'b0, rd);
         checks++;
         if (rd !== 16'h0000) begin errors++; $display("FAIL len%0d_bank2 got %h want 0000", lens[k], rd); end
         pulse_err_clr();
         checks++;
         if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL len%0d_clr got %b want 0", lens[k], bus.frame_err); end
      end
   endtask

   task automatic test_bad_addr();
      int          v0;
      logic [15:0] rd;
      v0 = valid_seen;
      send_bits(64'h12345676, 32, 3);
      repeat (8) @(negedge clk);
      checks += 4;
      if (valid_seen - v0 != 1) begin errors++; $display("FAIL addr6_pulses got %0d want 1", valid_seen - v0); end
      if (bus.frame_word !== 32'h12345676) begin errors++; $display("FAIL addr6_word got %h want 12345676", bus.frame_word); end
      if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL addr6_err got %b want 1", bus.frame_err); end
      if (bus.frame_cnt !== 8'd2) begin errors++; $display("FAIL addr6_cnt got %0d want 2", bus.frame_cnt); end
      read_reg(3'd6, 1'b0, rd);
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL addr6_rd6 got %h want 0000", rd); end
      for (int r = 0; r < 5; r++) begin
         read_reg(3'(r), 1'b1, rd);
         checks++;
         if (rd !== 16'h0000) begin errors++; $display("FAIL addr6_bank%0d got %h want 0000", r, rd); end
      end
      read_reg(3'd5, 1'b1, rd);
      checks++;
      if (rd !== 16'h0058) begin errors++; $display("FAIL addr6_bank5 got %h want 0058", rd); end
      pulse_err_clr();
   endtask

   task automatic test_err_clr_collision();
      send_bits(64'h5, 31, 3);
      // hold err_clr across the cycle in which the short frame is judged
      repeat (2) @(negedge clk);
      bus.err_clr = 1'b1;
      repeat (2) @(negedge clk);
      bus.err_clr = 1'b0;
      repeat (4) @(negedge clk);
      checks += 2;
      if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL collide_err got %b want 1", bus.frame_err); end
      if (bus.frame_cnt !== 8'd2) begin errors++; $display("FAIL collide_cnt got %0d want 2", bus.frame_cnt); end
      pulse_err_clr();
   endtask

   task automatic test_mid_reset();
      int          v0;
      logic [15:0] rd;
      v0 = valid_seen;
      bus.spi_cs = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         bus.spi_din = i[0];
         repeat (3) @(negedge clk);
         bus.spi_sclk = 1'b1;
         repeat (3) @(negedge clk);
         bus.spi_sclk = 1'b0;
      end
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      repeat (10) @(negedge clk);
      bus.spi_cs = 1'b1;
      repeat (10) @(negedge clk);
      checks += 3;
      if (valid_seen != v0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", valid_seen - v0); end
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", bus.frame_err); end
      if (bus.frame_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", bus.frame_cnt); end
      send_bits(64'h00000001, 32, 3);
      repeat (8) @(negedge clk);
      checks += 2;
      if (valid_seen - v0 != 1) begin errors++; $display("FAIL midrst_next_pulses got %0d want 1", valid_seen - v0); end
      if (bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_next_cnt got %0d want 1", bus.frame_cnt); end
      read_reg(3'd1, 1'b0, rd);
      checks++;
      if (rd !== 16'h0001) begin errors++; $display("FAIL midrst_bank1_lo got %h want 0001", rd); end
      read_reg(3'd1, 1'b1, rd);
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL midrst_bank1_hi got %h want 0000", rd); end
      read_reg(3'd5, 1'b0, rd);
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL midrst_bank5 got %h want 0000", rd); end
   endtask

   task automatic test_back_to_back();
      int          v0;
      logic [63:0] d;
      logic [15:0] rd;
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      repeat (10) @(negedge clk);
      v0 = valid_seen;
      for (int i = 0; i < 256; i++) begin
         d = (64'(i) << 8) | 64'(i % 6);
         send_bits(d, 32, 3);
         repeat (6) @(negedge clk);
         if (i == 254) begin
            checks++;
            if (bus.frame_cnt !== 8'd255) begin errors++; $display("FAIL b2b_cnt255 got %0d want 255", bus.frame_cnt); end
         end
      end
      repeat (4) @(negedge clk);
      checks += 4;
      if (valid_seen - v0 != 256) begin errors++; $display("FAIL b2b_pulses got %0d want 256", valid_seen - v0); end
      if (bus.frame_cnt !== 8'd0) begin errors++; $display("FAIL b2b_wrap got %0d want 0", bus.frame_cnt); end
      if (bus.frame_word !== 32'h0000FF03) begin errors++; $display("FAIL b2b_word got %h want 0000ff03", bus.frame_word); end
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b want 0", bus.frame_err); end
      read_reg(3'd3, 1'b0, rd);
      checks++;
      if (rd !== 16'hFF03) begin errors++; $display("FAIL b2b_bank3 got %h want ff03", rd); end
      read_reg(3'd0, 1'b0, rd);
      checks++;
      if (rd !== 16'hFC00) begin errors++; $display("FAIL b2b_bank0 got %h want fc00", rd); end
      read_reg(3'd5, 1'b0, rd);
      checks++;
      if (rd !== 16'hFB05) begin errors++; $display("FAIL b2b_bank5 got %h want fb05", rd); end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      clrn         = 1'b0;
      bus.spi_cs   = 1'b1;
      bus.spi_din  = 1'b0;
      bus.spi_sclk = 1'b0;
      bus.rd_sel   = 3'd0;
      bus.rd_hi    = 1'b0;
      bus.err_clr  = 1'b0;
      @(negedge clk);
      test_reset();
      test_r5();
      test_bad_len();
      test_bad_addr();
      test_err_clr_collision();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
